// File: rtl/rtc_bus_ctrl.sv
// Phased bus controller for a multiplexed-address/data RTC behind a PicoBlaze port.
// Optional BCD sanity check on read bytes: define RTC_BUS_BCD_CHECK_EN.
module rtc_bus_ctrl #(
  parameter int unsigned PHASE_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       rw_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic       rtc_cs_n_o,
  output logic       rtc_rd_n_o,
  output logic       rtc_wr_n_o,
  output logic       rtc_ad_o,
  output logic [7:0] ad_o,
  output logic       ad_oe_o,
  input  logic [7:0] ad_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_GAP   = 3'd2,
    S_DATA  = 3'd3,
    S_RECOV = 3'd4
  } state_t;

  localparam logic [7:0] PHASE_LAST = 8'(PHASE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q;
  logic       busy_q, done_q;
  logic       cs_n_q, rd_n_q, wr_n_q, ad_sel_q, oe_q;
  logic [7:0] ado_q;
  logic       cs_n_d, rd_n_d, wr_n_d, ad_sel_d, oe_d;
  logic [7:0] ado_d;
  logic       accept_s, phase_end_s, capture_s, done_d;

  assign phase_end_s = (cnt_q == PHASE_LAST);
  assign capture_s   = (state_q == S_DATA) && phase_end_s && rw_q;
  assign done_d      = (state_q == S_RECOV) && phase_end_s;

  // State register and phase counter
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; every non-idle phase runs PHASE_CYCLES cycles then advances
  always_comb begin
    state_d  = state_q;
    cnt_d    = 8'd0;
    accept_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d  = S_ADDR;
          accept_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR, S_GAP, S_DATA, S_RECOV: begin
        if (phase_end_s) begin
          cnt_d = 8'd0;
          case (state_q)
            S_ADDR:  state_d = S_GAP;
            S_GAP:   state_d = S_DATA;
            S_DATA:  state_d = S_RECOV;
            default: state_d = S_IDLE;
          endcase
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Transaction operands are captured only on an accepted start
  always_comb begin
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept_s) begin
      rw_d    = rw_i;
      addr_d  = addr_i;
      wdata_d = wdata_i;
    end else begin
      rw_d    = rw_q;
    end
  end

  // Bus pins are decoded from the upcoming state so the flops present them glitch-free
  always_comb begin
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_sel_d = 1'b1;
    oe_d     = 1'b0;
    ado_d    = 8'h00;
    case (state_d)
      S_ADDR: begin
        cs_n_d   = 1'b0;
        ad_sel_d = 1'b0;
        wr_n_d   = 1'b0;
        oe_d     = 1'b1;
        ado_d    = addr_d;
      end
      S_DATA: begin
        cs_n_d = 1'b0;
        if (rw_d) begin
          rd_n_d = 1'b0;
        end else begin
          wr_n_d = 1'b0;
          oe_d   = 1'b1;
          ado_d  = wdata_d;
        end
      end
      default: begin
        cs_n_d = 1'b1;
      end
    endcase
  end

  // Operand latches, read capture and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rw_q     <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      ad_sel_q <= 1'b1;
      oe_q     <= 1'b0;
      ado_q    <= 8'h00;
    end else begin
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= capture_s ? ad_i : rdata_q;
      busy_q   <= (state_d != S_IDLE);
      done_q   <= done_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      ad_sel_q <= ad_sel_d;
      oe_q     <= oe_d;
      ado_q    <= ado_d;
    end
  end

`ifdef RTC_BUS_BCD_CHECK_EN
  function automatic logic bcd_bad(input logic [7:0] b);
    return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
  endfunction

  logic err_q;

  // Error flag follows the last captured byte and clears when a new transaction starts
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else if (accept_s) begin
      err_q <= 1'b0;
    end else if (capture_s) begin
      err_q <= bcd_bad(ad_i);
    end else begin
      err_q <= err_q;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign rdata_o    = rdata_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign rtc_cs_n_o = cs_n_q;
  assign rtc_rd_n_o = rd_n_q;
  assign rtc_wr_n_o = wr_n_q;
  assign rtc_ad_o   = ad_sel_q;
  assign ad_oe_o    = oe_q;
  assign ad_o       = ado_q;

endmodule
